gate_truth_table_checker: RTL and testbench

GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

---
 rtl/gate_test_pkg.sv | 34 +++
 rtl/gate_ref_model.sv | 14 +
 rtl/gate_truth_table_checker.sv | 116 +++++++++++
 tb/tb_gate_truth_table_checker.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and golden gate function for the gate truth-table checker.
// Holds FSM state encoding, GATE_OP codes and the expected-value helper.
package gate_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  function automatic logic gate_eval(
    input logic       a,
    input logic       b,
    input logic [1:0] op
  );
    logic r;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of a two-input gate.
// Ports: a, b operands; op gate code; expected reference output.
module gate_ref_model
  import gate_test_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       expected
);

  assign expected = gate_eval(a, b, op);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks all four (a,b) vectors into a gate under test and grades y.
// Ports: clk, rst_n, start, y in; a, b, busy, done, pass, err_count, fail_vec out.
module gate_truth_table_checker
  import gate_test_pkg::*;
#(
  parameter int unsigned GATE_OP       = 0,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] OP     = 2'(GATE_OP);
  localparam logic [3:0] SET_LD = 4'(SETTLE_CYCLES);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_q;
  logic [3:0] fv_q;
  logic       exp_w;

  gate_ref_model u_ref (
    .a        (a_q),
    .b        (b_q),
    .op       (OP),
    .expected (exp_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // done is visible in the first IDLE cycle; a start
          // coinciding with it waits one more cycle.
          if (start && !done_q) begin
            err_q   <= '0;
            fv_q    <= '0;
            pass_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          a_q     <= idx_q[1];
          b_q     <= idx_q[0];
          cnt_q   <= SET_LD;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= '0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (y != exp_w) begin
            if (err_q != 3'd4) err_q <= err_q + 3'd1;
            fv_q[idx_q] <= 1'b1;
          end
          if (idx_q == 2'd3) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 3'd0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker.
// Three instances: AND/4, XOR/1, NAND/4 settle.
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [1:0] ymode;
  logic       y0, y1, y2;
  logic [2:0] a, b, busy, done, pass;
  logic [2:0] err [3];
  logic [3:0] fv  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    y0 = 1'b0;
    unique case (ymode)
      2'd0:    y0 = a[0] & b[0];
      2'd1:    y0 = 1'b1;
      default: y0 = ~(a[0] & b[0]);
    endcase
  end
  assign y1 = a[1] ^ b[1];
  assign y2 = 1'b0;

  gate_truth_table_checker #(.GATE_OP(0), .SETTLE_CYCLES(4)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .y(y0),
    .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0])
  );

  gate_truth_table_checker #(.GATE_OP(2), .SETTLE_CYCLES(1)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .y(y1),
    .a(a[1]), .b(b[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1])
  );

  gate_truth_table_checker #(.GATE_OP(3), .SETTLE_CYCLES(4)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .y(y2),
    .a(a[2]), .b(b[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err[2]), .fail_vec(fv[2])
  );

  // Pulses start on instance d and waits for done. seq holds (a,b)
  // seen just after each DRIVE; hold holds them at the SAMPLE cycle.
  task automatic run_pass(
    input  int         d,
    input  int         n,
    output int         lat,
    output logic [7:0] seq,
    output logic [7:0] hold
  );
    seq  = '0;
    hold = '0;
    lat  = -1;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (c == 2 + k * (n + 2)) seq[2*k +: 2] = {a[d], b[d]};
        if (c == 2 + k * (n + 2) + n) hold[2*k +: 2] = {a[d], b[d]};
      end
      if (done[d]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({a[d], b[d], busy[d], done[d], pass[d], err[d], fv[d]} !== 12'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got a%b b%b busy%b done%b pass%b err%0d fv%b required all 0",
                 d, a[d], b[d], busy[d], done[d], pass[d], err[d], fv[d]);
      end
    end
  endtask

  task automatic test_and_correct;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd0;
    run_pass(0, 4, lat, seq, hold);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("FAIL and_latency: got %0d required 25", lat);
    end
    vectors++;
    if ({pass[0], err[0], fv[0]} !== {1'b1, 3'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL and_result: got pass%b err%0d fv%b required pass1 err0 fv0000",
               pass[0], err[0], fv[0]);
    end
    vectors++;
    if (seq !== 8'hE4 || hold !== 8'hE4) begin
      miscompares++;
      $display("FAIL and_order: got seq %h hold %h required e4 e4", seq, hold);
    end
    @(negedge clk);
    vectors++;
    if ({done[0], busy[0], pass[0]} !== 3'b001) begin
      miscompares++;
      $display("FAIL and_done_pulse: got done%b busy%b pass%b required 0 0 1",
               done[0], busy[0], pass[0]);
    end
  endtask

  task automatic test_and_stuck1;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd1;
    run_pass(0, 4, lat, seq, hold);
    vectors++;
    if ({pass[0], err[0], fv[0]} !== {1'b0, 3'd3, 4'b0111}) begin
      miscompares++;
      $display("FAIL and_stuck1: got pass%b err%0d fv%b required pass0 err3 fv0111",
               pass[0], err[0], fv[0]);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if ({a[0], b[0], pass[0], err[0], fv[0], busy[0]} !== {2'b11, 1'b0, 3'd3, 4'b0111, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_hold: got a%b b%b pass%b err%0d fv%b busy%b required 1 1 0 3 0111 0",
               a[0], b[0], pass[0], err[0], fv[0], busy[0]);
    end
  endtask

  task automatic test_all_fail;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd2;
    run_pass(0, 4, lat, seq, hold);
    vectors++;
    if ({pass[0], err[0], fv[0]} !== {1'b0, 3'd4, 4'b1111}) begin
      miscompares++;
      $display("FAIL all_fail: got pass%b err%0d fv%b required pass0 err4 fv1111",
               pass[0], err[0], fv[0]);
    end
  endtask

  task automatic test_xor_fast;
    int lat;
    logic [7:0] seq, hold;
    run_pass(1, 1, lat, seq, hold);
    vectors++;
    if (lat !== 13) begin
      miscompares++;
      $display("FAIL xor_latency: got %0d required 13", lat);
    end
    vectors++;
    if ({pass[1], err[1], fv[1]} !== {1'b1, 3'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL xor_result: got pass%b err%0d fv%b required pass1 err0 fv0000",
               pass[1], err[1], fv[1]);
    end
    vectors++;
    if (seq !== 8'hE4 || hold !== 8'hE4) begin
      miscompares++;
      $display("FAIL xor_order: got seq %h hold %h required e4 e4", seq, hold);
    end
  endtask

  task automatic test_nand_stuck0;
    int lat;
    logic [7:0] seq, hold;
    run_pass(2, 4, lat, seq, hold);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("FAIL nand_latency: got %0d required 25", lat);
    end
    vectors++;
    if ({pass[2], err[2], fv[2]} !== {1'b0, 3'd3, 4'b0111}) begin
      miscompares++;
      $display("FAIL nand_stuck0: got pass%b err%0d fv%b required pass0 err3 fv0111",
               pass[2], err[2], fv[2]);
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd0;
    dones = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done[0]) dones++;
      start[0] = (c == 10);
    end
    start[0] = 1'b0;
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL b2b_dones: got %0d required 1", dones);
    end
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy %b required 0", busy[0]);
    end
    run_pass(0, 4, lat, seq, hold);
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("FAIL b2b_rerun: got latency %0d required 25", lat);
    end
  endtask

  task automatic test_start_on_done;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd0;
    run_pass(0, 4, lat, seq, hold);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL start_on_done_ignored: got busy %b required 0", busy[0]);
    end
    run_pass(0, 4, lat, seq, hold);
    start[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL start_after_done_taken: got busy %b required 1", busy[0]);
    end
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done[0]) begin
        lat = c;
        break;
      end
    end
    vectors++;
    if (lat < 0) begin
      miscompares++;
      $display("FAIL start_after_done_drain: got no done required done");
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    int lat;
    logic [7:0] seq, hold;
    ymode = 2'd1;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (14) @(negedge clk);
    vectors++;
    if ({a[0], b[0], busy[0], err[0], fv[0]} !== {2'b10, 1'b1, 3'd2, 4'b0011}) begin
      miscompares++;
      $display("FAIL pre_reset: got a%b b%b busy%b err%0d fv%b required 1 0 1 2 0011",
               a[0], b[0], busy[0], err[0], fv[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a[0], b[0], busy[0], done[0], pass[0], err[0], fv[0]} !== 12'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got a%b b%b busy%b done%b pass%b err%0d fv%b required all 0",
               a[0], b[0], busy[0], done[0], pass[0], err[0], fv[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[0] || busy[0]) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL aborted_pass_activity: got %0d cycles required 0", dones);
    end
    ymode = 2'd0;
    run_pass(0, 4, lat, seq, hold);
    vectors++;
    if (lat !== 25 || pass[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_pass: got lat %0d pass %b required 25 1", lat, pass[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = '0;
    ymode = 2'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_and_correct();
    test_and_stuck1();
    test_all_fail();
    test_xor_fast();
    test_nand_stuck0();
    test_back_to_back();
    test_start_on_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
